// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, timer width and keyboard command bytes.
package ps2_pkg;

    localparam int TMR_W = 21;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        WAIT_FIRST,
        SEND,
        WAIT_IDLE,
        ABORT
    } state_t;

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RESP_ACK    = 8'hFA;

    // Odd parity bit: makes the total count of ones over data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer followed by a FILTER_LEN consecutive-sample glitch filter.
//   clk, rst : system clock, synchronous active-low reset
//   line_i   : raw asynchronous line
//   line_o   : synchronized, filtered line (resets to 1, the idle bus level)
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_o
);

    localparam int CW = $clog2(FILTER_LEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          filt_q;

    // The output only moves after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_i};
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                filt_q <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with ACK check and protocol timeouts.
//   clk, rst                 : system clock, synchronous active-low reset
//   tx_data, tx_valid        : command byte and request (taken when tx_valid & tx_ready)
//   tx_ready, busy           : idle / transfer in progress
//   done, ack_err, timeout   : one-cycle completion pulses
//   ps2_clk_in, ps2_data_in  : raw bus lines
//   ps2_clk_oe, ps2_data_oe  : open-collector pull-low enables
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int XFER_TIMEOUT   = 200000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    // Expiry fires on the cycle the timer holds LIMIT-1, i.e. after LIMIT cycles in the phase.
    localparam logic [TMR_W-1:0] INH_LAST   = TMR_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] XFER_LAST  = TMR_W'(XFER_TIMEOUT - 1);

    state_t           state_q;
    logic [9:0]       frame_q;
    logic [3:0]       bit_cnt_q;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             ack_q;
    logic             clk_prev_q;
    logic             done_q, ack_err_q, timeout_q, clk_oe_q, data_oe_q;
    logic             clk_f, data_f, fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(clk), .rst(rst), .line_i(ps2_clk_in), .line_o(clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk(clk), .rst(rst), .line_i(ps2_data_in), .line_o(data_f)
    );

    assign fall    = clk_prev_q & ~clk_f;
    assign timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            ack_q      <= 1'b0;
            clk_prev_q <= 1'b1;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
        end else begin
            clk_prev_q <= clk_f;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            timer_q    <= timer_d;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        frame_q   <= {1'b1, odd_parity(tx_data), tx_data};
                        bit_cnt_q <= '0;
                        timer_q   <= '0;
                        clk_oe_q  <= 1'b1;
                        state_q   <= INHIBIT;
                    end
                end
                // Device falls here belong to a receive frame being cut off; ignore them.
                INHIBIT: begin
                    if (timer_q >= INH_LAST) begin
                        data_oe_q <= 1'b1;
                        state_q   <= RTS;
                    end
                end
                RTS: begin
                    clk_oe_q <= 1'b0;
                    timer_q  <= '0;
                    state_q  <= WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (timer_q >= START_LAST) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= ABORT;
                    end else if (fall) begin
                        data_oe_q <= ~frame_q[0];
                        bit_cnt_q <= 4'd1;
                        timer_q   <= '0;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (timer_q >= XFER_LAST) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= ABORT;
                    end else if (fall) begin
                        if (bit_cnt_q == 4'd10) begin
                            ack_q     <= data_f;
                            data_oe_q <= 1'b0;
                            state_q   <= WAIT_IDLE;
                        end else begin
                            data_oe_q <= ~frame_q[bit_cnt_q];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                // Timer keeps running from SEND so the whole transfer shares one budget.
                WAIT_IDLE: begin
                    if (timer_q >= XFER_LAST) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= ABORT;
                    end else if (clk_f && data_f) begin
                        done_q    <= ~ack_q;
                        ack_err_q <= ack_q;
                        state_q   <= IDLE;
                    end
                end
                ABORT:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready    = (state_q == IDLE);
    assign busy        = ~tx_ready;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout     = timeout_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam logic [2:0] EV_DONE = 3'b001;
    localparam logic [2:0] EV_ERR  = 3'b010;
    localparam logic [2:0] EV_TO   = 3'b100;

    typedef struct packed {
        logic [2:0] ev;
        logic [9:0] frame;
    } exp_t;

    logic       clk, rst;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, busy, done, ack_err, timeout;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;
    logic       ps2_clk_line, ps2_data_line;

    logic [9:0] cap_frame;
    logic       cap_start;
    int         cyc, first_fall_cyc;
    int         total, bad;
    exp_t       sb[$];

    assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(20), .START_TIMEOUT(500), .XFER_TIMEOUT(2000), .FILTER_LEN(2)
    ) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout),
        .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion pulse is matched against the oldest expected event.
    always @(negedge clk) begin
        exp_t e;
        if (rst && (done || ack_err || timeout)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {29'd0, timeout, ack_err, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("event", {29'd0, timeout, ack_err, done}, {29'd0, e.ev});
                if (e.ev != EV_TO) begin
                    chk("frame", {22'd0, cap_frame}, {22'd0, e.frame});
                    chk("start_bit", {31'd0, cap_start}, 32'd0);
                    chk("busy_at_end", {31'd0, busy}, 32'd0);
                end else begin
                    chk("clk_oe_at_to", {31'd0, ps2_clk_oe}, 32'd0);
                    chk("data_oe_at_to", {31'd0, ps2_data_oe}, 32'd0);
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation ran out of cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d, input bit push, input logic [2:0] ev, input logic [9:0] fr);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        if (push) sb.push_back('{ev: ev, frame: fr});
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device: waits for request-to-send, then clocks nf falls (40-cycle period), sampling on rises.
    task automatic dev_frame(input int nf, input logic ackv);
        int n = 0;
        while (!(busy && !ps2_clk_oe && !ps2_data_line) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("dev_rts_seen", {31'd0, n < 500}, 32'd1);
        repeat (10) @(negedge clk);
        cap_start = ps2_data_line;
        for (int i = 0; i < nf; i++) begin
            dev_clk = 1'b0;
            if (i == 0) first_fall_cyc = cyc;
            repeat (20) @(negedge clk);
            if (i < 10) cap_frame[i] = ps2_data_line;
            dev_clk = 1'b1;
            if (i == 10) dev_data = 1'b1;
            if (i == 9) begin
                repeat (5) @(negedge clk);
                dev_data = ackv;
                repeat (15) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
            end
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", {31'd0, n < 3000}, 32'd1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int n, d;
        total = 0; bad = 0; cyc = 0; first_fall_cyc = 0;
        rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk = 1'b1; dev_data = 1'b1;
        cap_frame = '0; cap_start = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulses", {29'd0, timeout, ack_err, done}, 32'd0);
        chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // 1: 0xED acked; frame {stop=1, parity=1 (six ones), 0xED}
        send(CMD_SET_LED, 1, EV_DONE, 10'h3ED);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("inhibit_len", n, 32'd20);
        chk("rts_both_low", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd3);
        @(negedge clk);
        chk("release_data_low", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd1);
        dev_frame(11, 1'b0);
        wait_idle();

        // 2: 0xFF with ACK=1 -> ack_err
        send(CMD_RESET, 1, EV_ERR, 10'h3FF);
        dev_frame(11, 1'b1);
        wait_idle();

        // 3: device silent -> timeout 500 cycles after clk release
        send(CMD_ENABLE, 1, EV_TO, 10'h000);
        n = 0;
        while (ps2_clk_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!timeout && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("start_timeout_len", n, 32'd500);
        @(negedge clk);
        chk("ready_after_to", {31'd0, tx_ready}, 32'd1);

        // 4: device stops after 5 falls -> transfer timeout, then 0xF4 (parity 0) succeeds
        send(CMD_ENABLE, 1, EV_TO, 10'h000);
        dev_frame(5, 1'b0);
        n = 0;
        while (!timeout && n < 2500) begin
            @(negedge clk);
            n++;
        end
        d = cyc - first_fall_cyc;
        chk("xfer_to_window", {31'd0, d >= 2000 && d <= 2010}, 32'd1);
        if (!(d >= 2000 && d <= 2010)) $display("  xfer timeout distance was %0d cycles", d);
        @(negedge clk);
        chk("ready_after_xto", {31'd0, tx_ready}, 32'd1);
        send(CMD_ENABLE, 1, EV_DONE, 10'h2F4);
        dev_frame(11, 1'b0);
        wait_idle();

        // 5: tx_valid held with changing data while busy -> only 0xED goes out
        @(negedge clk);
        tx_data  = CMD_SET_LED;
        tx_valid = 1'b1;
        sb.push_back('{ev: EV_DONE, frame: 10'h3ED});
        @(negedge clk);
        fork
            dev_frame(11, 1'b0);
            begin
                n = 0;
                while (!tx_ready && n < 3000) begin
                    tx_data = tx_data ^ 8'h3C;
                    @(negedge clk);
                    n++;
                end
                tx_valid = 1'b0;
            end
        join
        chk("held_valid_bound", {31'd0, n < 3000}, 32'd1);
        repeat (50) @(negedge clk);
        chk("no_second_accept", {31'd0, busy}, 32'd0);

        // 6: reset while bit 4 of 0xED (a 0 -> data pulled) is on the wire
        send(CMD_SET_LED, 0, EV_DONE, 10'h000);
        dev_frame(5, 1'b0);
        chk("pre_rst_data_oe", {31'd0, ps2_data_oe}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("rst_mid_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_mid_pulses", {29'd0, timeout, ack_err, done}, 32'd0);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        send(CMD_SET_LED, 1, EV_DONE, 10'h3ED);
        dev_frame(11, 1'b0);
        wait_idle();

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
